// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its decoders.
package mdu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negator.
module mdu_negate #(
  parameter int unsigned W = 32
) (
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  assign y_o = en_i ? (~x_i + {{(W-1){1'b0}}, 1'b1}) : x_i;

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
module mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [1:0]      hilo_we_i,
  input  logic [XLEN-1:0] wd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  import mdu_pkg::*;

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic                div_q, neg_res_q, neg_rem_q, divz_q;
  logic [XLEN-1:0]     opb_q, a_q;

  logic                accept;
  logic                op_signed, op_div;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum;
  logic [XLEN+1:0]     trial;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix;

  assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign op_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);

  mdu_negate #(.W(XLEN)) u_neg_a (
    .en_i (op_signed & a_i[XLEN-1]), .x_i (a_i), .y_o (a_mag)
  );
  mdu_negate #(.W(XLEN)) u_neg_b (
    .en_i (op_signed & b_i[XLEN-1]), .x_i (b_i), .y_o (b_mag)
  );

  // Multiply keeps the multiplier in the low half and shifts the sum in from the top.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Shifted remainder can reach XLEN+1 bits; the extra guard bit gives the borrow.
  assign trial    = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
  assign div_next = trial[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  mdu_negate #(.W(2*XLEN)) u_neg_prod (
    .en_i (neg_res_q), .x_i (acc_q), .y_o (prod_fix)
  );
  mdu_negate #(.W(XLEN)) u_neg_quot (
    .en_i (neg_res_q), .x_i (acc_q[XLEN-1:0]), .y_o (quot_fix)
  );
  mdu_negate #(.W(XLEN)) u_neg_rem (
    .en_i (neg_rem_q), .x_i (acc_q[2*XLEN-1:XLEN]), .y_o (rem_fix)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hilo_we_i[1]) hi_d = wd_i;
        if (hilo_we_i[0]) lo_d = wd_i;
        if (start_i) begin
          accept  = 1'b1;
          state_d = CALC;
          busy_d  = 1'b1;
          cnt_d   = '0;
          acc_d   = {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
        end
      end
      CALC: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!div_q) begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end else if (divz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      opb_q     <= '0;
      a_q       <= '0;
    end else if (accept) begin
      div_q     <= op_div;
      neg_res_q <= op_signed & (a_i[XLEN-1] ^ b_i[XLEN-1]);
      neg_rem_q <= op_signed & a_i[XLEN-1];
      divz_q    <= op_div & (b_i == '0);
      opb_q     <= op_div ? b_mag : a_mag;
      a_q       <= a_i;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed, table-driven bench for mdu with hand-written multi-cycle sequences.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [1:0]  hilo_we_i = 2'b00;
  logic [31:0] wd_i = '0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .hilo_we_i (hilo_we_i),
    .wd_i      (wd_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok, output bit stable_ok);
    logic [31:0] h0, l0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    busy_ok   = (busy_o === 1'b1) && (done_o === 1'b0);
    stable_ok = 1'b1;
    h0 = hi_o; l0 = lo_o; lat = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done_o !== 1'b1) begin
        if (busy_o !== 1'b1) busy_ok = 1'b0;
        if (hi_o !== h0 || lo_o !== l0) stable_ok = 1'b0;
      end else if (busy_o !== 1'b0) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t vecs[10];
    int   lat, dcnt;
    bit   bok, sok;

    vecs[0] = '{"multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_m3x5",  2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{"div_m7d2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_7d2",   2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{"div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{"divu_by0",   2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[6] = '{"div_neg_by0",2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{"mult_min2",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{"div_7dm2",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{"multu_sh",   2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok, sok);
      chk({vecs[i].name, "_lat"}, lat, 33);
      chk({vecs[i].name, "_busy"}, {31'b0, bok}, 32'd1);
      chk({vecs[i].name, "_stable"}, {31'b0, sok}, 32'd1);
      chk({vecs[i].name, "_hi"}, hi_o, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo_o, vecs[i].lo);
      if (i == 0) begin
        @(posedge clk); #1;
        chk("done_drop", {31'b0, done_o}, 32'd0);
      end
    end

    // MTLO, then MTHI+MTLO together.
    @(negedge clk); hilo_we_i = 2'b01; wd_i = 32'h0000_1234;
    @(posedge clk); #1; hilo_we_i = 2'b00;
    chk("mtlo_lo", lo_o, 32'h0000_1234);
    chk("mtlo_hi", hi_o, 32'h4000_0000 ^ 32'h3FFF_FFFF ^ 32'h7FFF_FFFE); // prior hi 0x0000_0001
    @(negedge clk); hilo_we_i = 2'b11; wd_i = 32'hA5A5_5A5A;
    @(posedge clk); #1; hilo_we_i = 2'b00;
    chk("mtboth_hi", hi_o, 32'hA5A5_5A5A);
    chk("mtboth_lo", lo_o, 32'hA5A5_5A5A);

    // MTHI in the same cycle as start: visible at E0, later overwritten by the result.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd7; b_i = 32'd2; hilo_we_i = 2'b10; wd_i = 32'h0000_0077;
    @(posedge clk); #1; start_i = 1'b0; hilo_we_i = 2'b00;
    chk("same_cyc_hi", hi_o, 32'h0000_0077);
    lat = 0;
    while (done_o !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("same_cyc_lat", lat, 33);
    chk("same_cyc_res_hi", hi_o, 32'd1);
    chk("same_cyc_res_lo", lo_o, 32'd3);

    // start and MTHI while busy are ignored.
    @(negedge clk); start_i = 1'b1; op_i = 2'b01; a_i = 32'd6; b_i = 32'd7;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); start_i = 1'b1; op_i = 2'b11; a_i = 32'd100; b_i = 32'd3;
    hilo_we_i = 2'b10; wd_i = 32'hDEAD_BEEF;
    @(posedge clk); #1; start_i = 1'b0; hilo_we_i = 2'b00;
    chk("busy_mthi_ign", hi_o, 32'd1);
    dcnt = 0;
    repeat (45) begin @(posedge clk); #1; if (done_o === 1'b1) dcnt++; end
    chk("busy_done_once", dcnt, 1);
    chk("busy_res_hi", hi_o, 32'd0);
    chk("busy_res_lo", lo_o, 32'd42);
    chk("busy_idle", {31'b0, busy_o}, 32'd0);

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk); start_i = 1'b1; op_i = 2'b10; a_i = 32'hFFFF_FFF9; b_i = 32'd2;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'b0, busy_o}, 32'd0);
    chk("mrst_done", {31'b0, done_o}, 32'd0);
    chk("mrst_hi", hi_o, 32'd0);
    chk("mrst_lo", lo_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, lat, bok, sok);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_busy", {31'b0, bok}, 32'd1);
    chk("post_rst_hi", hi_o, 32'd0);
    chk("post_rst_lo", lo_o, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the multi-cycle MIPS datapath. It sits directly downstream of the register file and takes rs/rt read data as operands. It executes MULT, MULTU, DIV and DIVU over 32 iterations into architectural HI/LO registers. It also serves MTHI/MTLO writes and provides HI/LO for MFHI/MFLO write-back into the register file.

## Interface
Parameters:
- XLEN, 32, operand/HI/LO width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  start request; accepted only in IDLE.
- op_i  in  2  operation, sampled with start_i: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a_i  in  32  rs operand (multiplicand / dividend).
- b_i  in  32  rt operand (multiplier / divisor).
- hilo_we_i  in  2  bit1 MTHI, bit0 MTLO; accepted only in IDLE.
- wd_i  in  32  MTHI/MTLO data.
- busy_o  out  1  high while an operation is in progress; registered; reset 0.
- done_o  out  1  one-cycle pulse when HI/LO receive a result; registered; reset 0.
- hi_o  out  32  HI register; reset 0.
- lo_o  out  32  LO register; reset 0.

## Operation
States:
- IDLE -> CALC on start_i.
  - Latches op, sign flags and operand magnitudes.
  - Signed ops: magnitude = two's-complement negation if the MSB is set. Unsigned ops: operand is used as is.
  - Clears the 6-bit iteration counter.
- CALC: one iteration per cycle. After 32 iterations -> FIX.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring shift-subtract. 64-bit {rem, quot} register; the 33-bit trial subtract sets the quotient bit.
- FIX -> IDLE. Applies the sign, writes HI/LO, pulses done_o.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.

Results:
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: LO = quotient (truncated toward zero), HI = remainder.
- Divide by zero (b = 0, signed or unsigned): LO = 32'hFFFF_FFFF, HI = a_i as captured. Latency is unchanged.
- DIV 0x8000_0000 / 0xFFFF_FFFF gives LO = 0x8000_0000, HI = 0. This falls out of the magnitude algorithm with no special case.

Boundary rules:
- start_i while busy is ignored; op/operands are not re-sampled.
- hilo_we_i while busy is ignored.
- hilo_we_i and start_i in the same IDLE cycle:
  - The MTHI/MTLO write applies at that edge.
  - The computation result later overwrites both HI and LO.
- hilo_we_i = 11 writes wd_i to both HI and LO.
- Reset asserted mid-operation: state IDLE, HI/LO = 0, busy_o = 0, done_o = 0 immediately; the partial result is discarded.

## Timing
- Start accepted at edge E0: busy_o = 1 after E0.
- Iterations run at E1..E32; FIX executes at E33.
- After E33: HI/LO hold the result, done_o = 1, busy_o = 0, state IDLE.
- After E34: done_o = 0.
- Next start is accepted at E34 at the earliest. Throughput is one operation per 34 cycles.
- MTHI/MTLO write at edge E is visible on hi_o/lo_o after E.
- hi_o/lo_o are stable during CALC; they are never updated with intermediate values.
- Outputs are register-driven, with no combinational path from inputs to outputs.

## Structure
- Shared package mdu_pkg:
  - XLEN
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, CALC, FIX
  - the iteration count constant (32)
- The decode stage imports the op encodings from mdu_pkg.
- One sub-module is natural: mdu_negate, a conditional two's-complement negator (parameterised width). It is instantiated for operand magnitude (32) and result sign fix (64).
- Iteration datapath, counter and FSM stay in mdu.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF started at E0 -> done_o after E33 only; HI = 0xFFFF_FFFE, LO = 0x0000_0001; busy_o high exactly E0..E33.
- MULT −3 (0xFFFF_FFFD) × 5 -> HI = 0xFFFF_FFFF, LO = 0xFFFF_FFF1.
- DIV −7 / 2 -> LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- DIVU 7 / 2 -> LO = 3, HI = 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> LO = 0x8000_0000, HI = 0.
- DIVU 5 / 0 -> LO = 0xFFFF_FFFF, HI = 5.
- MTLO 0x1234 in IDLE -> lo_o = 0x1234 next cycle.
- start_i and MTHI during busy -> no effect: HI/LO show only the original op's result; done_o pulses once.
- rst_n low at cycle 10 of a DIV -> busy_o, done_o, hi_o, lo_o = 0 immediately. After release, MULTU 6 × 7 -> LO = 42, HI = 0 at normal latency.
